// File: rtl/nn_seq_pkg.sv
// Shared types, sizes and the default weight table for the time-multiplexed 2-2-1 XOR network.
package nn_seq_pkg;

  localparam int unsigned SM_W        = 17;
  localparam int unsigned MAG_W       = 16;
  localparam int unsigned PROD_W      = 32;
  localparam int unsigned ACT_W       = 33;
  localparam int unsigned ACC_W       = 34;
  localparam int unsigned NUM_WEIGHTS = 9;
  localparam int unsigned N_TERMS     = 3;
  localparam int unsigned WIDX_W      = 4;
  localparam int unsigned CNT_W       = 2;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sm_word_t;

  typedef struct packed {
    logic              sign;
    logic [PROD_W-1:0] mag;
  } act_word_t;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_ACT  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam acc_t ACC_SAT = acc_t'({2'b00, {PROD_W{1'b1}}});

  // Entry [i] is weight index i = neuron*3 + term (term 2 is the bias).
  localparam logic [NUM_WEIGHTS-1:0][SM_W-1:0] DEFAULT_WEIGHTS = {
    17'h1FFFF, 17'h007FF, 17'h007FF,
    17'h0FFFF, 17'h107FF, 17'h107FF,
    17'h1001F, 17'h007FF, 17'h007FF
  };

  // Two's complement accumulator to sign-magnitude; zero always comes out as +0.
  function automatic act_word_t acc_to_act(input acc_t acc);
    act_word_t r;
    acc_t      neg;
    neg    = -acc;
    r.sign = acc[ACC_W-1];
    r.mag  = acc[ACC_W-1] ? neg[PROD_W-1:0] : acc[PROD_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/nn_sm_mac.sv
// Combinational sign-magnitude multiply (or shifted bias) followed by a saturating accumulate.
module nn_sm_mac
  import nn_seq_pkg::*;
#(
  parameter int unsigned BIAS_SHIFT = 0
) (
  input  sm_word_t operand_i,
  input  sm_word_t weight_i,
  input  logic     bias_i,
  input  acc_t     acc_i,
  output acc_t     acc_c_o
);

  logic [PROD_W-1:0] mag_c;
  logic              neg_c;
  acc_t              mag_ext_c;
  acc_t              term_c;
  acc_t              sum_c;

  always_comb begin
    mag_c     = '0;
    neg_c     = 1'b0;
    mag_ext_c = '0;
    term_c    = '0;
    sum_c     = '0;
    acc_c_o   = acc_i;

    if (bias_i) begin
      mag_c = PROD_W'(weight_i.mag) << BIAS_SHIFT;
      neg_c = weight_i.sign;
    end else begin
      mag_c = PROD_W'(operand_i.mag) * PROD_W'(weight_i.mag);
      neg_c = operand_i.sign ^ weight_i.sign;
    end

    mag_ext_c = acc_t'({2'b00, mag_c});
    term_c    = neg_c ? -mag_ext_c : mag_ext_c;
    sum_c     = acc_i + term_c;

    // Clamp every step so the running sum always fits the 32-bit magnitude of act_in.
    if (sum_c > ACC_SAT) begin
      acc_c_o = ACC_SAT;
    end else if (sum_c < -ACC_SAT) begin
      acc_c_o = -ACC_SAT;
    end else begin
      acc_c_o = sum_c;
    end
  end

endmodule

// File: rtl/nn_mac_sequencer.sv
// Sequences one shared MAC over the nine terms of the 2-2-1 XOR network (h1, h2, then y).
// Define NN_SEQ_CFG_EN to add a runtime-writable weight table (cfg_we/cfg_addr/cfg_data).
module nn_mac_sequencer
  import nn_seq_pkg::*;
#(
  parameter int unsigned BIAS_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SM_W-1:0]   x1,
  input  logic [SM_W-1:0]   x2,
`ifdef NN_SEQ_CFG_EN
  input  logic              cfg_we,
  input  logic [WIDX_W-1:0] cfg_addr,
  input  logic [SM_W-1:0]   cfg_data,
`endif
  output logic              busy,
  output logic              done,
  output logic [SM_W-1:0]   y_out,
  output logic [ACT_W-1:0]  act_in,
  input  logic [SM_W-1:0]   act_out,
  output logic              act_valid
);

  state_e           state_q, state_d;
  sm_word_t         x1_q, x1_d;
  sm_word_t         x2_q, x2_d;
  sm_word_t         h1_q, h1_d;
  sm_word_t         h2_q, h2_d;
  sm_word_t         y_q, y_d;
  acc_t             acc_q, acc_d;
  act_word_t        act_q, act_d;
  logic [CNT_W-1:0] neuron_q, neuron_d;
  logic [CNT_W-1:0] term_q, term_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             act_valid_q, act_valid_d;

  logic [WIDX_W-1:0] widx_c;
  sm_word_t          wt_c;
  sm_word_t          operand_c;
  acc_t              mac_acc_c;

  assign widx_c = WIDX_W'(neuron_q) * WIDX_W'(N_TERMS) + WIDX_W'(term_q);

`ifdef NN_SEQ_CFG_EN
  sm_word_t wt_q [NUM_WEIGHTS];

  // Table may only change while fully idle so an inference never sees a mixed table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WEIGHTS; i++) begin
        wt_q[i] <= sm_word_t'(DEFAULT_WEIGHTS[i]);
      end
    end else if (cfg_we && (state_q == ST_IDLE) && (cfg_addr < WIDX_W'(NUM_WEIGHTS))) begin
      wt_q[cfg_addr] <= sm_word_t'(cfg_data);
    end
  end

  assign wt_c = wt_q[widx_c];
`else
  assign wt_c = sm_word_t'(DEFAULT_WEIGHTS[widx_c]);
`endif

  always_comb begin
    operand_c = '0;
    case (term_q)
      2'd0:    operand_c = (neuron_q == 2'd2) ? h1_q : x1_q;
      2'd1:    operand_c = (neuron_q == 2'd2) ? h2_q : x2_q;
      default: operand_c = '0;
    endcase
  end

  nn_sm_mac #(
    .BIAS_SHIFT (BIAS_SHIFT)
  ) u_mac (
    .operand_i (operand_c),
    .weight_i  (wt_c),
    .bias_i    (term_q == CNT_W'(N_TERMS - 1)),
    .acc_i     (acc_q),
    .acc_c_o   (mac_acc_c)
  );

  always_comb begin
    state_d     = state_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    h1_d        = h1_q;
    h2_d        = h2_q;
    y_d         = y_q;
    acc_d       = acc_q;
    act_d       = act_q;
    neuron_d    = neuron_q;
    term_d      = term_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x1_d     = sm_word_t'(x1);
          x2_d     = sm_word_t'(x2);
          acc_d    = '0;
          neuron_d = '0;
          term_d   = '0;
          state_d  = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d  = mac_acc_c;
        act_d  = acc_to_act(mac_acc_c);
        term_d = term_q + CNT_W'(1);
        if (term_q == CNT_W'(N_TERMS - 1)) begin
          term_d  = '0;
          state_d = ST_ACT;
        end
      end
      ST_ACT: begin
        case (neuron_q)
          2'd0:    h1_d = sm_word_t'(act_out);
          2'd1:    h2_d = sm_word_t'(act_out);
          default: y_d  = sm_word_t'(act_out);
        endcase
        acc_d    = '0;
        term_d   = '0;
        neuron_d = neuron_q + CNT_W'(1);
        state_d  = (neuron_q == 2'd2) ? ST_DONE : ST_MAC;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy rises one cycle after the start edge and drops together with the done pulse.
    busy_d      = (state_q == ST_MAC) || (state_q == ST_ACT);
    done_d      = (state_q == ST_DONE);
    act_valid_d = (state_d == ST_ACT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x1_q        <= '0;
      x2_q        <= '0;
      h1_q        <= '0;
      h2_q        <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      act_q       <= '0;
      neuron_q    <= '0;
      term_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      act_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      h1_q        <= h1_d;
      h2_q        <= h2_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      act_q       <= act_d;
      neuron_q    <= neuron_d;
      term_q      <= term_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      act_valid_q <= act_valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign y_out     = y_q;
  assign act_in    = act_q;
  assign act_valid = act_valid_q;

endmodule

// File: tb/tb_nn_mac_sequencer.sv
// Self-checking bench for nn_mac_sequencer: directed and random inferences against an arithmetic model.
module tb_nn_mac_sequencer;

  localparam int unsigned BIAS_SHIFT = 0;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [16:0] x1;
  logic [16:0] x2;
  logic        busy;
  logic        done;
  logic [16:0] y_out;
  logic [32:0] act_in;
  logic [16:0] act_out;
  logic        act_valid;
`ifdef NN_SEQ_CFG_EN
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [16:0] cfg_data;
`endif

  int checks = 0;
  int errors = 0;

  logic [16:0] wt [9] = '{17'h007FF, 17'h007FF, 17'h1001F,
                          17'h107FF, 17'h107FF, 17'h0FFFF,
                          17'h007FF, 17'h007FF, 17'h1FFFF};
  logic [32:0] e_act [3];
  logic [16:0] e_y;
  logic [32:0] cap [3];

  // Activation stub: top 16 magnitude bits of act_in with its sign.
  assign act_out = {act_in[32], act_in[31:16]};

  nn_mac_sequencer #(.BIAS_SHIFT(BIAS_SHIFT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x1        (x1),
    .x2        (x2),
`ifdef NN_SEQ_CFG_EN
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
`endif
    .busy      (busy),
    .done      (done),
    .y_out     (y_out),
    .act_in    (act_in),
    .act_out   (act_out),
    .act_valid (act_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint smv(input logic [16:0] v);
    longint m;
    m = longint'(v[15:0]);
    return v[16] ? -m : m;
  endfunction

  function automatic longint sat(input longint v);
    longint lim;
    lim = 64'h0000_0000_FFFF_FFFF;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic logic [32:0] to_act(input longint v);
    longint m;
    m = (v < 0) ? -v : v;
    return {(v < 0), m[31:0]};
  endfunction

  // Whole-network reference: three neurons, each two products plus a bias, stub between layers.
  task automatic model_run(input logic [16:0] a, input logic [16:0] b);
    logic [16:0] in0, in1, hh1, hh2, s;
    longint acc;
    hh1 = '0;
    hh2 = '0;
    for (int n = 0; n < 3; n++) begin
      in0 = (n == 2) ? hh1 : a;
      in1 = (n == 2) ? hh2 : b;
      acc = 0;
      acc = sat(acc + smv(in0) * smv(wt[3*n]));
      acc = sat(acc + smv(in1) * smv(wt[3*n+1]));
      acc = sat(acc + smv(wt[3*n+2]) * (longint'(1) << BIAS_SHIFT));
      e_act[n] = to_act(acc);
      s = {e_act[n][32], e_act[n][31:16]};
      if (n == 0) hh1 = s;
      else if (n == 1) hh2 = s;
      else e_y = s;
    end
  endtask

  // One inference, checking busy/done/act_valid every cycle. mode 1: start/x1 glitch at cycle 5;
  // mode 2: cfg write attempted while busy.
  task automatic run_inf(input logic [16:0] a, input logic [16:0] b, input int mode, input string tag);
    model_run(a, b);
    @(negedge clk);
    x1 = a;
    x2 = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s_busy_c%0d", tag, k), 64'(busy), 64'(k <= 12));
      chk($sformatf("%s_done_c%0d", tag, k), 64'(done), 64'(k == 13));
      chk($sformatf("%s_actv_c%0d", tag, k), 64'(act_valid), 64'((k == 3) || (k == 7) || (k == 11)));
      if ((k == 3) || (k == 7) || (k == 11)) begin
        cap[(k-3)/4] = act_in;
        chk($sformatf("%s_act_n%0d", tag, (k-3)/4), 64'(act_in), 64'(e_act[(k-3)/4]));
      end
      if (k == 13) chk($sformatf("%s_y", tag), 64'(y_out), 64'(e_y));
      if (mode == 1 && k == 5) begin
        start = 1'b1;
        x1 = a ^ 17'h1ABCD;
        x2 = b ^ 17'h05555;
      end else if (mode == 1 && k == 6) begin
        start = 1'b0;
      end
`ifdef NN_SEQ_CFG_EN
      if (mode == 2 && k == 2) begin
        cfg_we = 1'b1;
        cfg_addr = 4'd0;
        cfg_data = 17'h00001;
      end else if (mode == 2 && k == 3) begin
        cfg_we = 1'b0;
      end
`endif
    end
  endtask

`ifdef NN_SEQ_CFG_EN
  task automatic cfg_write(input logic [3:0] addr, input logic [16:0] data);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    if (addr <= 4'd8) wt[addr] = data;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x1 = '0;
    x2 = '0;
`ifdef NN_SEQ_CFG_EN
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
`endif
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_y", 64'(y_out), 64'(0));
    chk("rst_act_in", 64'(act_in), 64'(0));
    chk("rst_act_valid", 64'(act_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_done", 64'(done), 64'(0));
    end

    run_inf(17'h0FFFF, 17'h0FFFF, 0, "ones");
    chk("ones_n0_const", 64'(cap[0]), 64'(33'h0_0FFD_EFE3));
    chk("ones_n1_const", 64'(cap[1]), 64'(33'h1_0FFC_F003));

    run_inf(17'h00000, 17'h00000, 0, "zeros");
    chk("zeros_n0_const", 64'(cap[0]), 64'(33'h1_0000_001F));
    chk("zeros_n1_const", 64'(cap[1]), 64'(33'h0_0000_FFFF));

    run_inf(17'h00123, 17'h10456, 1, "glitch");

    for (int r = 0; r < 6; r++) begin
      run_inf(17'($urandom), 17'($urandom), 0, $sformatf("rand%0d", r));
    end

    // Abort an inference with reset after its 7th edge.
    @(negedge clk);
    x1 = 17'h0ABCD;
    x2 = 17'h11234;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_y", 64'(y_out), 64'(0));
    chk("abort_act_in", 64'(act_in), 64'(0));
    chk("abort_act_valid", 64'(act_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", 64'(done), 64'(0));
    end
    run_inf(17'h0ABCD, 17'h11234, 0, "after_abort");

`ifdef NN_SEQ_CFG_EN
    cfg_write(4'd0, 17'h0FFFF);
    cfg_write(4'd1, 17'h0FFFF);
    cfg_write(4'd2, 17'h00000);
    run_inf(17'h0FFFF, 17'h0FFFF, 2, "cfg_sat");
    chk("cfg_sat_n0_const", 64'(cap[0]), 64'(33'h0_FFFF_FFFF));
    run_inf(17'h0FFFF, 17'h0FFFF, 0, "cfg_busy_write_dropped");
    cfg_write(4'd9, 17'h1FFFF);
    run_inf(17'h10F0F, 17'h00333, 0, "cfg_addr_oob");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nn_mac_sequencer.md
Name: nn_mac_sequencer

Overview:
Time-multiplexed controller for the 2-2-1 XOR network. One shared multiply-accumulate path is sequenced over all nine weight/bias terms (h1, h2, then y), replacing six parallel multipliers and nine adders. Each neuron's accumulator is presented to the external squish/sigmoid chain through an activation port. A start/busy/done handshake launches one inference on latched inputs x1, x2.

Parameters:
BIAS_SHIFT, 0, left shift applied to bias magnitude before accumulation (aligns bias with product scale)
N_TERMS, 3, terms per neuron (two weights + bias); fixed, not for override

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request inference; sampled only in IDLE
x1  input  17  input 1, sign-magnitude (bit16 sign, [15:0] magnitude)
x2  input  17  input 2, same format
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse, y_out valid
y_out  output  17  network output, held until next done
act_in  output  33  accumulator to squish, sign-magnitude (bit32 sign)
act_out  input  17  sigmoid result, combinational from act_in
act_valid  output  1  high in ACT state (act_out captured that cycle)

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low (rst_n). Reset values: busy=0, done=0, y_out=0, act_in=0, act_valid=0, acc=0, h1=h2=0, state IDLE.
- Reset asserted mid-inference: immediate abort, all of the above cleared, no done.
- States: IDLE, MAC, ACT, DONE.
- IDLE: start=1 latches x1/x2, clears acc, sets neuron=0, term=0 -> MAC.
- MAC: one term per cycle.
  - Operand: term0 = x1 (neuron 0,1) or h1 (neuron 2); term1 = x2 or h2; term2 = bias.
  - Weight index = neuron*3 + term.
  - After term2 -> ACT.
- ACT: act_valid=1; act_out registered into h1 (n0), h2 (n1) or y_out (n2). acc cleared, term=0, neuron++.
  - Next state MAC, or DONE after neuron 2.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- Latency: done asserted on the 13th rising edge after the edge that samples start. Back-to-back starts allowed from IDLE.
- start while busy/DONE: ignored. Input changes while busy: ignored.
- Arithmetic:
  - product = mag(a)*mag(w), 32-bit unsigned; sign = sign(a) XOR sign(w).
  - Bias term = mag(b)<<BIAS_SHIFT with sign(b).
  - Accumulate in 34-bit two's complement; saturate per step to +/-(2^32-1).
  - act_in = sign-magnitude conversion of acc, valid in MAC term2 result onward through ACT.
  - Negative zero is normalised to +0.
- Default weight table (index: value): 0:17'h007FF, 1:17'h007FF, 2:17'h1001F, 3:17'h107FF, 4:17'h107FF, 5:17'h0FFFF, 6:17'h007FF, 7:17'h007FF, 8:17'h1FFFF.

Optional Feature:
Macro NN_SEQ_CFG_EN.
- Defined: adds ports cfg_we (1), cfg_addr (4), cfg_data (17). The weight table becomes a register file, reset to the default table.
  - A write takes effect next cycle when busy=0 and not in DONE.
  - Writes while busy, or with cfg_addr>8, are dropped.
- Undefined: no cfg ports; table is the package constant.

Decomposition:
- Package nn_seq_pkg:
  - 17-bit sign-magnitude word typedef, 33-bit act typedef.
  - State enum.
  - Default weight table constant, NUM_WEIGHTS=9, ACC_SAT=2^32-1.
- Sub-module nn_sm_mac: combinational sign-magnitude multiply/bias-shift plus saturating accumulate. The sequencer owns state, counters and registers.

Test Plan:
Bench stub for activation: act_out = {act_in[32], act_in[31:16]}.
- Reset: hold rst_n=0 -> busy=0, done=0, y_out=0, act_in=0. Release, no start -> remains idle.
- x1=17'h0FFFF, x2=17'h0FFFF, start pulse -> n0 ACT act_in=33'h0_0FFD_EFE3; n1 ACT act_in=33'h1_0FFC_F003; done exactly 13 edges after start edge, busy high 12 cycles.
- x1=x2=0 -> n0 act_in=33'h1_0000_001F, n1 act_in=33'h0_0000_FFFF; y_out equals stub-driven n2 result; done single-cycle.
- start re-pulsed and x1 toggled at cycle 5 of an inference -> ignored; y_out unchanged from original-input result.
- rst_n low at cycle 7 of an inference -> immediate clear, no done; a new start afterwards completes normally in 13 edges.
- NN_SEQ_CFG_EN: write addr0=addr1=17'h0FFFF, addr2=0 while idle, x1=x2=17'h0FFFF -> n0 act_in saturates to 33'h0_FFFF_FFFF. Write during busy -> table unchanged.
